// File: rtl/mtp_pkg.sv
// mtp_pkg: shared state encoding, vector sizing and saturating increment for the mtp sweep controller
package mtp_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int NUM_VEC = 4;
  localparam int IDX_W = 2;
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
    return (v == (32'(1) << w) - 32'd1) ? v : v + 32'd1;
  endfunction
endpackage

// File: rtl/mtp_settle_cnt.sv
// mtp_settle_cnt: counts settle cycles and ticks when the held vector is ready to sample
module mtp_settle_cnt #(
  parameter int SETTLE = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tick
);
  logic [3:0] cnt;
  always_comb tick = enable && cnt == 4'(SETTLE);
  always_ff @(posedge clk)
    cnt <= (rst || clear || tick) ? '0 : enable ? cnt + 4'd1 : cnt;
endmodule

// File: rtl/mtp_sweep_ctrl.sv
// mtp_sweep_ctrl: walks a two-input unit through all vectors, builds its truth table and checks it
module mtp_sweep_ctrl
  import mtp_pkg::*;
#(
  parameter int SETTLE = 2,
  parameter logic [3:0] EXPECTED = 4'b0110,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             mtpz,
  output logic             mtpx,
  output logic             mtpy,
  output logic             busy,
  output logic             done,
  output logic [3:0]       tt,
  output logic             match,
  output logic [CNT_W-1:0] run_cnt,
  output logic [CNT_W-1:0] err_cnt
);
  state_t state;
  logic [IDX_W-1:0] idx;
  logic [3:0] sh, sh_nxt;
  logic tick;
  always_comb begin
    sh_nxt = sh;
    sh_nxt[idx] = mtpz;
  end
  mtp_settle_cnt #(.SETTLE(SETTLE)) u_cnt (
    .clk(clk),
    .rst(rst),
    .clear(state != RUN || abort),
    .enable(state == RUN),
    .tick(tick)
  );
  // tt/match/counters update on the final sample edge so they are valid alongside done
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      sh <= '0;
      {mtpx, mtpy} <= 2'b00;
      busy <= 1'b0;
      done <= 1'b0;
      tt <= '0;
      match <= 1'b0;
      run_cnt <= '0;
      err_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state <= RUN;
          idx <= '0;
          sh <= '0;
          {mtpx, mtpy} <= 2'b00;
          busy <= 1'b1;
        end
        RUN: if (abort) begin
          state <= IDLE;
          {mtpx, mtpy} <= 2'b00;
          busy <= 1'b0;
        end else if (tick) begin
          sh <= sh_nxt;
          if (idx == IDX_W'(NUM_VEC - 1)) begin
            state <= DONE;
            {mtpx, mtpy} <= 2'b00;
            busy <= 1'b0;
            done <= 1'b1;
            tt <= sh_nxt;
            match <= sh_nxt == EXPECTED;
            run_cnt <= CNT_W'(sat_inc(32'(run_cnt), CNT_W));
            if (sh_nxt != EXPECTED) err_cnt <= CNT_W'(sat_inc(32'(err_cnt), CNT_W));
          end else begin
            idx <= idx + 1'b1;
            {mtpx, mtpy} <= idx + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          done <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/mtp_sweep_ctrl.md
Name: mtp_sweep_ctrl

Overview:
- Sequencer for the shared two-input combinational unit `top` (inputs mtpx/mtpy, output mtpz).
- On a start request it walks the unit through all four input combinations and holds each for a programmable settle time.
- It samples mtpz once per combination and assembles a 4-bit truth table, then compares it against an expected pattern.
- Keeps saturating run and mismatch counters. Sits between a host/test controller and the `top` instance.

Parameters:
- SETTLE, 2, cycles each vector is held before mtpz is sampled (0..15).
- EXPECTED, 4'b0110, golden truth table; bit k is the expected mtpz for vector k = {mtpx,mtpy}.
- CNT_W, 8, width of the run and mismatch counters.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a sweep; honoured only in IDLE.
- abort  input  1  cancels an in-progress sweep.
- mtpz  input  1  output of the `top` unit under control (combinational path).
- mtpx  output  1  drives `top` input x (registered).
- mtpy  output  1  drives `top` input y (registered).
- busy  output  1  high while a sweep is in progress.
- done  output  1  one-cycle pulse when a sweep completes.
- tt  output  4  last completed truth table; bit k = sampled mtpz for vector k.
- match  output  1  tt == EXPECTED, valid after the first completed sweep.
- run_cnt  output  CNT_W  completed sweeps, saturating.
- err_cnt  output  CNT_W  completed sweeps with match=0, saturating.

Behaviour:
- Reset (synchronous, when rst=1 at a clk edge):
  - state=IDLE; mtpx=mtpy=0; busy=0; done=0; tt=0; match=0; run_cnt=0; err_cnt=0.
  - rst overrides start and abort.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 -> RUN.
  - vector index idx=0 and settle count cnt=0; mtpx=0, mtpy=0 on the same edge.
  - busy=1 from the next cycle.
- RUN:
  - {mtpx,mtpy}=idx, held stable; cnt increments each cycle.
  - When cnt==SETTLE: capture mtpz into shadow bit sh[idx], set cnt=0.
  - If idx<3: idx+1, and the outputs change on the same edge.
  - If idx==3: -> DONE.
  - Each vector therefore occupies SETTLE+1 cycles. With SETTLE=0, every RUN cycle samples.
- DONE (one cycle):
  - done=1; tt<=sh; match<=(sh==EXPECTED).
  - run_cnt+1, saturating at 2^CNT_W-1.
  - err_cnt+1 if sh!=EXPECTED, same saturation.
  - mtpx=mtpy=0; busy=0; -> IDLE.
- Latency:
  - start sampled at edge E0.
  - done high in the cycle starting at edge E0 + 4*(SETTLE+1).
  - busy high for exactly 4*(SETTLE+1) cycles.
- start while busy or in DONE: ignored (not queued).
- abort=1 in RUN:
  - -> IDLE on the next edge; mtpx=mtpy=0.
  - No done pulse; tt, match and the counters are unchanged; the shadow bits are discarded.
- abort in IDLE or DONE: no effect. DONE always completes and updates.
- Simultaneous start and abort in IDLE: start wins (abort has no effect in IDLE).
- Wrap-around: the counters never wrap; they saturate.
- mtpz is sampled only on a sample edge. Glitches during settle are ignored by design.

Decomposition:
- Shared package mtp_pkg holds:
  - state enum (IDLE/RUN/DONE);
  - NUM_VEC=4 and IDX_W=2;
  - a saturating-increment function used by both counters.
- One natural sub-module: mtp_settle_cnt, the settle counter.
  - Inputs: clear, enable. Parameter: SETTLE.
  - Output: a one-cycle tick when cnt==SETTLE.
  - Instantiated once inside mtp_sweep_ctrl.
- The controller and `top` are wired together one level up, not inside this block.

Test Plan:
- Reset mid-sweep: rst=1 at cycle 5 of a sweep -> next cycle all outputs 0, state IDLE, no done.
- Nominal sweep, SETTLE=2, mtpz model = XOR (0110):
  - pulse start -> mtpx,mtpy step 00,01,10,11, each held 3 cycles; busy=1 for 12 cycles.
  - done pulses at cycle 12; tt=4'b0110, match=1, run_cnt=1, err_cnt=0.
- Mismatch, mtpz model = AND (1000):
  - run twice -> tt=4'b1000, match=0, run_cnt=2, err_cnt=2.
- Abort then retry:
  - abort on the 2nd vector -> busy drops next cycle, no done, tt and counters unchanged.
  - New start -> full 12-cycle sweep completes normally.
- start held high continuously, SETTLE=0:
  - sweeps of 4 busy cycles each, with DONE + IDLE gap cycles between them.
  - Starts during busy/DONE are ignored; run_cnt increments once per sweep.
- Saturation, CNT_W=2, mismatching model:
  - 5 sweeps -> run_cnt=3, err_cnt=3, and both stay at 3.
